// File: rtl/inv_mix_columns_iter.sv
// inv_mix_columns_iter -- iterative AES (Inv)MixColumns engine.
//
// Takes one 128-bit state over valid/ready and transforms COLS_PER_CYCLE
// columns per clock. The result is held on out_data/out_valid until the
// downstream accepts it.
//
// Parameters:
//   COLS_PER_CYCLE  columns per clock: 1, 2 or 4 (compute cycles = 4/COLS_PER_CYCLE)
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   in_valid/ready  input handshake; in_data = state, column c at [127-32c -: 32]
//   out_valid/ready output handshake; out_data uses the same packing
//   busy            high while a block is being computed or held
//   mode_fwd        (MIXCOL_FWD_EN only) 1 = forward MixColumns for this block
// Build option:
//   MIXCOL_FWD_EN   adds mode_fwd and forward MixColumns support.

// One column: bytes a0..a3 (a0 = MSB) times the circulant matrix.
module inv_mix_col_lane (
    input  logic [31:0] col,
    input  logic        fwd,
    output logic [31:0] res
);
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];

    always_comb begin
        res = '0;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2[i] = xt(a[i]);
            x4[i] = xt(x2[i]);
            x8[i] = xt(x4[i]);
        end
        for (int i = 0; i < 4; i++) begin
            if (fwd)
                // 02*a[i] ^ 03*a[i+1] ^ a[i+2] ^ a[i+3]
                res[31-8*i -: 8] = x2[i] ^ (x2[(i+1)%4] ^ a[(i+1)%4])
                                 ^ a[(i+2)%4] ^ a[(i+3)%4];
            else
                // 0e*a[i] ^ 0b*a[i+1] ^ 0d*a[i+2] ^ 09*a[i+3]
                res[31-8*i -: 8] = (x8[i] ^ x4[i] ^ x2[i])
                                 ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ a[(i+1)%4])
                                 ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4])
                                 ^ (x8[(i+3)%4] ^ a[(i+3)%4]);
        end
    end
endmodule

module inv_mix_columns_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
`ifdef MIXCOL_FWD_EN
    input  logic         mode_fwd,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
        $error("COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_nxt;
    logic [3:0][31:0] work;     // work[3] holds column 0, i.e. index = ~col
    logic [3:0][31:0] res_q;
    logic [1:0]       col_cnt;
    logic             mode_q;
    logic             last_step;

    logic [COLS_PER_CYCLE-1:0][31:0] lane_in;
    logic [COLS_PER_CYCLE-1:0][31:0] lane_out;

    assign last_step = (col_cnt == 2'(4 - COLS_PER_CYCLE));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_data  = res_q;

    for (genvar l = 0; l < COLS_PER_CYCLE; l++) begin : g_lane
        logic [1:0] cidx;
        assign cidx       = col_cnt + 2'(l);
        assign lane_in[l] = work[~cidx];
        inv_mix_col_lane u_lane (
            .col (lane_in[l]),
            .fwd (mode_q),
            .res (lane_out[l])
        );
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = BUSY;
            BUSY:    if (last_step) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            work    <= '0;
            res_q   <= '0;
            col_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    work    <= in_data;
                    col_cnt <= '0;
                end
                BUSY: begin
                    for (int l = 0; l < COLS_PER_CYCLE; l++)
                        res_q[~(col_cnt + 2'(l))] <= lane_out[l];
                    // 2-bit wrap returns the counter to 0 as BUSY ends
                    col_cnt <= col_cnt + 2'(COLS_PER_CYCLE);
                end
                default: ;
            endcase
        end
    end

`ifdef MIXCOL_FWD_EN
    // Mode is captured with the data so a toggle mid-block cannot corrupt it.
    always_ff @(posedge clk) begin
        if (rst)                        mode_q <= 1'b0;
        else if (state == IDLE && in_valid) mode_q <= mode_fwd;
    end
`else
    assign mode_q = 1'b0;
`endif
endmodule

// File: tb/tb_inv_mix_columns_iter.sv
module tb_inv_mix_columns_iter;
    localparam int CPC = 1;
    localparam int NC  = 4 / CPC;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic         busy;
`ifdef MIXCOL_FWD_EN
    logic         mode_fwd = 1'b0;
    bit           blk_tog = 1'b0;
`endif
    bit           blk_fwd = 1'b0;

    int n_chk = 0;
    int n_pass = 0;

    inv_mix_columns_iter #(.COLS_PER_CYCLE(CPC)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef MIXCOL_FWD_EN
        .mode_fwd  (mode_fwd),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: generic GF(2^8) multiply, matrix rows from rotated coefficients.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        logic [7:0] x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_state(input logic [127:0] s, input bit fwd);
        logic [7:0]   coef [4];
        logic [127:0] r = '0;
        logic [31:0]  col;
        logic [7:0]   acc;
        if (fwd) begin coef[0]=8'h02; coef[1]=8'h03; coef[2]=8'h01; coef[3]=8'h01; end
        else     begin coef[0]=8'h0e; coef[1]=8'h0b; coef[2]=8'h0d; coef[3]=8'h09; end
        for (int c = 0; c < 4; c++) begin
            col = s[127-32*c -: 32];
            for (int i = 0; i < 4; i++) begin
                acc = '0;
                for (int j = 0; j < 4; j++)
                    acc ^= gmul(coef[(j - i + 4) % 4], col[31-8*j -: 8]);
                r[127-32*c-8*i -: 8] = acc;
            end
        end
        return r;
    endfunction

    // One block: accept, measure latency, optionally hold off out_ready, release.
    task automatic do_block(input string tag, input logic [127:0] d,
                            input logic [127:0] exp, input int hold);
        int  n;
        bit  ok;
        logic [127:0] held;
        in_data   = d;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
`ifdef MIXCOL_FWD_EN
        mode_fwd = blk_fwd;
`endif
        chk({tag, "_rdy"}, 128'(in_ready), 128'd1);
        tick();
        in_valid = 1'b0;
        chk({tag, "_busy"}, 128'(busy), 128'd1);
        n = 0;
        while (!out_valid && n < 20) begin
`ifdef MIXCOL_FWD_EN
            if (blk_tog) mode_fwd = ~mode_fwd;
`endif
            tick();
            n++;
        end
        chk({tag, "_lat"}, 128'(n), 128'(NC));
        chk({tag, "_data"}, out_data, exp);
        if (hold > 0) begin
            ok   = 1'b1;
            held = out_data;
            for (int h = 0; h < hold; h++) begin
                in_valid = 1'b1;
                in_data  = {$urandom, $urandom, $urandom, $urandom};
                tick();
                in_valid = 1'b0;
                if (!out_valid || out_data !== held || in_ready) ok = 1'b0;
            end
            chk({tag, "_hold"}, 128'(ok), 128'd1);
            out_ready = 1'b1;
        end
        tick();
        chk({tag, "_rel"}, {126'd0, out_valid, in_ready}, {126'd0, 1'b0, 1'b1});
    endtask

    localparam logic [127:0] V_IN  = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
    localparam logic [127:0] V_OUT = 128'hdb135345_f20a225c_01010101_2d26314c;
    localparam logic [127:0] I_IN  = 128'hc6c6c6c6_01010101_d5d5d7d6_4d7ebdf8;
    localparam logic [127:0] I_OUT = 128'hc6c6c6c6_01010101_d4d4d4d5_2d26314c;

    bit ov_seen = 1'b0;
    bit mon_en  = 1'b0;
    always @(negedge clk) if (mon_en && out_valid) ov_seen = 1'b1;

    initial begin
        logic [127:0] d;
        logic [127:0] q[$];
        int acc_t[$];
        int cyc;

        // reset state
        tick(); tick();
        rst = 1'b0;
        chk("rst_flags", {125'd0, in_ready, out_valid, busy}, {125'd0, 1'b1, 1'b0, 1'b0});
        chk("rst_data", out_data, 128'd0);

        // known vector and invariant columns
        do_block("known", V_IN, V_OUT, 0);
        do_block("invar", I_IN, I_OUT, 0);
        // backpressure with ignored in_valid pulses
        do_block("bp", V_IN, V_OUT, 10);

        // reset while computing
        in_data = I_IN; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        mon_en = 1'b1;
        repeat ((NC > 2) ? NC - 2 : 0) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_flags", {126'd0, in_ready, busy}, {126'd0, 1'b1, 1'b0});
        repeat (6) tick();
        chk("mrst_noval", 128'(ov_seen), 128'd0);
        mon_en = 1'b0;
        do_block("after_rst", V_IN, V_OUT, 0);

`ifdef MIXCOL_FWD_EN
        blk_fwd = 1'b1;
        do_block("fwd_known", V_OUT, V_IN, 0);
        blk_fwd = 1'b0; blk_tog = 1'b1;
        do_block("mode_tog", V_IN, V_OUT, 0);
        blk_tog = 1'b0;
`endif

        // randomized blocks against the reference model
        for (int k = 0; k < 16; k++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
`ifdef MIXCOL_FWD_EN
            blk_fwd = 1'($urandom_range(0, 1));
`else
            blk_fwd = 1'b0;
`endif
            do_block("rand", d, ref_state(d, blk_fwd), int'($urandom_range(0, 3)));
        end
        blk_fwd = 1'b0;
`ifdef MIXCOL_FWD_EN
        mode_fwd = 1'b0;
`endif

        // back-to-back: in_valid held high, out_ready high
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = {$urandom, $urandom, $urandom, $urandom};
        cyc = 0;
        while (acc_t.size() < 3 && cyc < 100) begin
            if (in_valid && in_ready) begin
                acc_t.push_back(cyc);
                q.push_back(ref_state(in_data, 1'b0));
            end
            tick();
            cyc++;
            if (acc_t.size() > 0 && !busy) in_data = {$urandom, $urandom, $urandom, $urandom};
            if (out_valid && q.size() > 0) chk("b2b_data", out_data, q.pop_front());
        end
        in_valid = 1'b0;
        chk("b2b_cnt", 128'(acc_t.size()), 128'd3);
        if (acc_t.size() == 3) begin
            chk("b2b_per1", 128'(acc_t[1] - acc_t[0]), 128'(NC + 2));
            chk("b2b_per2", 128'(acc_t[2] - acc_t[1]), 128'(NC + 2));
        end
        cyc = 0;
        while (q.size() > 0 && cyc < 20) begin
            tick();
            cyc++;
            if (out_valid) chk("b2b_tail", out_data, q.pop_front());
        end
        chk("b2b_drain", 128'(q.size()), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
